// File: rtl/fft_peak_detect_if.sv
// Sink stream from fft_int and the peak/error result bus of fft_peak_detect.
interface fft_peak_detect_if #(
  parameter int POW        = 11,
  parameter int DATA_WIDTH = 20,
  parameter int MAG_WIDTH  = 2*DATA_WIDTH+1
);
  localparam int BW = (POW > 0) ? POW : 1;

  logic                         sink_sop;
  logic                         sink_eop;
  logic                         sink_valid;
  logic signed [DATA_WIDTH-1:0] sink_Re;
  logic signed [DATA_WIDTH-1:0] sink_Im;

  logic                         peak_valid;
  logic [BW-1:0]                peak_bin;
  logic [MAG_WIDTH-1:0]         peak_mag;
  logic signed [DATA_WIDTH-1:0] peak_Re;
  logic signed [DATA_WIDTH-1:0] peak_Im;
  logic                         error;

  modport master (
    output sink_sop, sink_eop, sink_valid, sink_Re, sink_Im,
    input  peak_valid, peak_bin, peak_mag, peak_Re, peak_Im, error
  );

  modport slave (
    input  sink_sop, sink_eop, sink_valid, sink_Re, sink_Im,
    output peak_valid, peak_bin, peak_mag, peak_Re, peak_Im, error
  );
endinterface

// File: rtl/fft_peak_detect.sv
// Finds the largest |X|^2 bin of each FFT packet and reports index, power and value.
// Optional macro FFT_PEAK_SKIP_DC_EN excludes bin 0 from the search.
//
// state | meaning
// IDLE  | waiting for sop; any other accepted beat is a framing error
// FRAME | inside a packet, counting bins until eop
module fft_peak_detect #(
  parameter int POW        = 11,
  parameter int DATA_WIDTH = 20,
  parameter int MAG_WIDTH  = 2*DATA_WIDTH+1
) (
  input logic              clk,
  input logic              aclr_n,
  fft_peak_detect_if.slave bus
);
  localparam int BW = (POW > 0) ? POW : 1;
  localparam int CW = POW + 1;
  localparam int PW = 2*DATA_WIDTH;
  localparam logic [CW-1:0] LAST = CW'((1 << POW) - 1);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tag_vld, tag_first, tag_pub, tag_err;
  logic [BW-1:0]   tag_bin;
  logic signed [PW-1:0] sq_re, sq_im;
  logic            skip_dc;

  logic                         s1_vld_q, s1_first_q, s1_pub_q, s1_err_q;
  logic [BW-1:0]                s1_bin_q;
  logic signed [DATA_WIDTH-1:0] s1_re_q, s1_im_q;
  logic [PW-1:0]                s1_re2_q, s1_im2_q;

  logic                         s2_vld_q, s2_first_q, s2_pub_q, err_q;
  logic [BW-1:0]                s2_bin_q;
  logic signed [DATA_WIDTH-1:0] s2_re_q, s2_im_q;
  logic [MAG_WIDTH-1:0]         s2_mag_q;

  logic                         pub_q;
  logic [BW-1:0]                max_bin_q;
  logic [MAG_WIDTH-1:0]         max_mag_q;
  logic signed [DATA_WIDTH-1:0] max_re_q, max_im_q;

  logic                         peak_valid_q;
  logic [BW-1:0]                peak_bin_q;
  logic [MAG_WIDTH-1:0]         peak_mag_q;
  logic signed [DATA_WIDTH-1:0] peak_re_q, peak_im_q;

`ifdef FFT_PEAK_SKIP_DC_EN
  assign skip_dc = (POW > 0);
`else
  assign skip_dc = 1'b0;
`endif

  assign sq_re = PW'(bus.sink_Re) * PW'(bus.sink_Re);
  assign sq_im = PW'(bus.sink_Im) * PW'(bus.sink_Im);

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tag_vld   = 1'b0;
    tag_first = 1'b0;
    tag_pub   = 1'b0;
    tag_err   = 1'b0;
    tag_bin   = bus.sink_sop ? '0 : BW'(cnt_q + 1'b1);
    if (bus.sink_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.sink_sop && !bus.sink_eop) begin
            state_d   = FRAME;
            cnt_d     = '0;
            tag_vld   = 1'b1;
            tag_first = 1'b1;
          end else begin
            tag_err = 1'b1;
          end
        end
        FRAME: begin
          if (bus.sink_sop && bus.sink_eop) begin
            tag_err = 1'b1;
            state_d = IDLE;
          end else if (bus.sink_sop) begin
            // restart: the new sop beat reloads the running max
            tag_err   = 1'b1;
            cnt_d     = '0;
            tag_vld   = 1'b1;
            tag_first = 1'b1;
          end else if (bus.sink_eop) begin
            state_d = IDLE;
            if (cnt_q + 1'b1 == LAST) begin
              tag_vld = 1'b1;
              tag_pub = 1'b1;
            end else begin
              tag_err = 1'b1;
            end
          end else begin
            cnt_d   = cnt_q + 1'b1;
            tag_vld = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      s1_vld_q <= 1'b0; s1_first_q <= 1'b0; s1_pub_q <= 1'b0; s1_err_q <= 1'b0;
      s1_bin_q <= '0;   s1_re_q    <= '0;   s1_im_q  <= '0;
      s1_re2_q <= '0;   s1_im2_q   <= '0;
      s2_vld_q <= 1'b0; s2_first_q <= 1'b0; s2_pub_q <= 1'b0; err_q <= 1'b0;
      s2_bin_q <= '0;   s2_re_q    <= '0;   s2_im_q  <= '0;   s2_mag_q <= '0;
    end else begin
      s1_vld_q   <= tag_vld;
      s1_first_q <= tag_first;
      s1_pub_q   <= tag_pub;
      s1_err_q   <= tag_err;
      s1_bin_q   <= tag_bin;
      s1_re_q    <= bus.sink_Re;
      s1_im_q    <= bus.sink_Im;
      s1_re2_q   <= PW'(sq_re);
      s1_im2_q   <= PW'(sq_im);
      s2_vld_q   <= s1_vld_q;
      s2_first_q <= s1_first_q;
      s2_pub_q   <= s1_pub_q;
      err_q      <= s1_err_q;
      s2_bin_q   <= s1_bin_q;
      s2_re_q    <= s1_re_q;
      s2_im_q    <= s1_im_q;
      s2_mag_q   <= MAG_WIDTH'(s1_re2_q) + MAG_WIDTH'(s1_im2_q);
    end
  end

  // strict greater-than keeps the lowest index on ties
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      pub_q     <= 1'b0;
      max_bin_q <= '0;
      max_mag_q <= '0;
      max_re_q  <= '0;
      max_im_q  <= '0;
    end else begin
      pub_q <= s2_vld_q && s2_pub_q;
      if (s2_vld_q && s2_first_q && skip_dc) begin
        max_bin_q <= BW'(1);
        max_mag_q <= '0;
        max_re_q  <= '0;
        max_im_q  <= '0;
      end else if (s2_vld_q && (s2_first_q || (s2_mag_q > max_mag_q))) begin
        max_bin_q <= s2_bin_q;
        max_mag_q <= s2_mag_q;
        max_re_q  <= s2_re_q;
        max_im_q  <= s2_im_q;
      end
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      peak_re_q    <= '0;
      peak_im_q    <= '0;
    end else begin
      peak_valid_q <= pub_q;
      if (pub_q) begin
        peak_bin_q <= max_bin_q;
        peak_mag_q <= max_mag_q;
        peak_re_q  <= max_re_q;
        peak_im_q  <= max_im_q;
      end
    end
  end

  assign bus.peak_valid = peak_valid_q;
  assign bus.peak_bin   = peak_bin_q;
  assign bus.peak_mag   = peak_mag_q;
  assign bus.peak_Re    = peak_re_q;
  assign bus.peak_Im    = peak_im_q;
  assign bus.error      = err_q;
endmodule

// File: doc/fft_peak_detect.md
# fft_peak_detect

Streaming consumer for the source side of `fft_int`. It takes one complex FFT output packet per frame, framed by sop/eop/valid, and computes |X|² for every bin. At end of packet it reports the bin index, magnitude and complex value of the largest bin. It sits directly after `fft_int` and feeds spectral-peak results (carrier frequency and phase) to downstream control logic.

## Interface
- `POW`, 11, frame length N = 2**POW bins
- `DATA_WIDTH`, 20, width of signed Re/Im inputs (matches `fft_int` RES_WIDTH)
- `MAG_WIDTH`, 2*DATA_WIDTH+1, width of unsigned |X|² result
- `clk` in 1: single clock; all logic on rising edge
- `aclr_n` in 1: asynchronous, active-low reset
- `sink_sop` in 1: start of packet, qualified by `sink_valid`
- `sink_eop` in 1: end of packet, qualified by `sink_valid`
- `sink_valid` in 1: input beat valid
- `sink_Re` in DATA_WIDTH: signed real part
- `sink_Im` in DATA_WIDTH: signed imaginary part
- `peak_valid` out 1: one-cycle result strobe
- `peak_bin` out POW: index of the maximum bin
- `peak_mag` out MAG_WIDTH: Re²+Im² of the maximum bin
- `peak_Re` out DATA_WIDTH: real part of the maximum bin
- `peak_Im` out DATA_WIDTH: imaginary part of the maximum bin
- `error` out 1: one-cycle framing-error strobe

## Operation
- Beat accepted only when `sink_valid`=1; cycles with `sink_valid`=0 are stalls, and no state advances.
- FSM states: IDLE, FRAME.
  - IDLE + accepted sop → FRAME. Bin counter = 0. Running max is loaded with this beat.
  - IDLE + accepted beat without sop → `error` pulse; beat discarded; stay IDLE.
  - FRAME + accepted beat without sop/eop → counter++, compare.
  - FRAME + accepted eop with counter+1 == N-1 → compare, publish result, → IDLE.
  - FRAME + accepted eop with any other count → `error` pulse, no result, → IDLE.
  - FRAME + accepted sop → `error` pulse; current frame dropped; new frame starts from this beat (stay FRAME, counter = 0).
  - sop and eop on the same accepted beat → `error`, no result, → IDLE.
- Arithmetic:
  - Re² and Im² are computed at full precision, signed×signed; the sum is unsigned MAG_WIDTH with no truncation or saturation.
  - Most-negative input is legal: (-2^(DATA_WIDTH-1))² fits.
- Compare:
  - The new bin replaces the max only if strictly greater. Ties keep the lowest index.
  - An all-zero frame reports bin 0 (or bin 1 with DC skip), mag 0.
- Results are held on `peak_*` until the next published result. They are not cleared on error.

## Timing
- Two-stage pipeline: stage 1 registers squares plus the sop/eop/index tags; stage 2 registers sum and compare.
- `peak_valid` goes high for exactly one cycle, 3 rising edges after the edge that accepted eop. `peak_*` is valid in that same cycle.
- `error` goes high for one cycle, 1 edge after the offending beat is accepted.
- Back-to-back frames are supported: sop may be accepted on the edge immediately after eop, and both results are published with no loss.
- Reset (asynchronous `aclr_n`=0):
  - FSM → IDLE; counter, pipeline tags and running max → 0.
  - Outputs: `peak_valid`=0, `error`=0, `peak_bin`=0, `peak_mag`=0, `peak_Re`=0, `peak_Im`=0.
  - Reset mid-frame discards the frame and produces no strobe. The first sop after release starts cleanly.

## Configuration
- `FFT_PEAK_SKIP_DC_EN` defined:
  - Bin 0 is excluded from the search. The running max initialises to mag 0 / bin 1 at sop, and bin 0 data is ignored apart from counting.
  - With POW=0 the macro has no effect.
- Undefined: all N bins are searched, including DC.

## Test plan
- POW=3, DATA_WIDTH=8: continuous frame, all bins (1,1) except bin 5 = (100,-50) → `peak_valid` 3 edges after eop, `peak_bin`=5, `peak_mag`=12500, `peak_Re`=100, `peak_Im`=-50.
- Same frame with random `sink_valid`=0 gaps between beats → identical result; the strobe is 3 edges after the eop edge.
- Bins 2 and 6 both (-128,-128), others 0 → `peak_bin`=2, `peak_mag`=32768. Then a back-to-back second frame with bin 7 = (3,4) → second result `peak_bin`=7, `peak_mag`=25.
- Eop on the 6th beat; then sop mid-frame; then a beat while IDLE → three `error` pulses, no `peak_valid`, prior `peak_*` retained.
- With `FFT_PEAK_SKIP_DC_EN`: bin 0 = (127,0), bin 3 = (10,0), others 0 → `peak_bin`=3, `peak_mag`=100. Without the macro: `peak_bin`=0, `peak_mag`=16129.
- Assert `aclr_n`=0 after 4 beats of a frame → all outputs 0 immediately. A following full frame reports correctly, and no strobe comes from the aborted frame.
